// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the RV64 subset ld, sd, beq and R-type ALU ops.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes
// on both memories, holds the instruction register and counts retirements.
// Datapath strobes are decoded combinationally from the current state and IR.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] instruction,
    input  logic        dmem_ready,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic        zero,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    state_t      state_r;
    logic [31:0] ir_r;
    logic [31:0] retired_r;
    logic        trap_r;

    logic        is_ld_s;
    logic        is_sd_s;
    logic        is_beq_s;
    logic        is_rtype_s;
    logic        is_legal_s;
    logic        retire_s;

    logic        imem_req_s;
    logic        dmem_read_s;
    logic        dmem_write_s;
    logic        pc_write_s;
    logic        pc_src_s;
    logic        alu_src_s;
    logic [1:0]  alu_op_s;
    logic        reg_write_s;
    logic        mem_to_reg_s;

    // Opcode class of the instruction currently held in IR
    always_comb begin
        is_ld_s    = 1'b0;
        is_sd_s    = 1'b0;
        is_beq_s   = 1'b0;
        is_rtype_s = 1'b0;
        case (ir_r[6:0])
            OP_LD:    is_ld_s    = 1'b1;
            OP_SD:    is_sd_s    = 1'b1;
            OP_BEQ:   is_beq_s   = 1'b1;
            OP_RTYPE: is_rtype_s = 1'b1;
            default:  is_ld_s    = 1'b0;
        endcase
        is_legal_s = is_ld_s | is_sd_s | is_beq_s | is_rtype_s;
    end

    // Strobe decode from state and IR; everything is held low while reset is high
    always_comb begin
        imem_req_s   = 1'b0;
        dmem_read_s  = 1'b0;
        dmem_write_s = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        alu_src_s    = 1'b0;
        alu_op_s     = 2'b00;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        retire_s     = 1'b0;
        if (reset) begin
            retire_s = 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    imem_req_s = 1'b1;
                    pc_write_s = imem_ready;
                end
                EXEC: begin
                    if (is_ld_s || is_sd_s) begin
                        alu_src_s = 1'b1;
                        alu_op_s  = 2'b00;
                    end else if (is_rtype_s) begin
                        alu_op_s = 2'b10;
                    end else if (is_beq_s) begin
                        alu_op_s   = 2'b01;
                        pc_src_s   = 1'b1;
                        pc_write_s = zero;
                        retire_s   = 1'b1;
                    end else begin
                        alu_op_s = 2'b00;
                    end
                end
                MEM: begin
                    alu_src_s = 1'b1;
                    if (is_ld_s) begin
                        dmem_read_s = 1'b1;
                    end else if (is_sd_s) begin
                        dmem_write_s = 1'b1;
                        retire_s     = dmem_ready;
                    end else begin
                        dmem_read_s = 1'b0;
                    end
                end
                WB: begin
                    reg_write_s  = 1'b1;
                    mem_to_reg_s = is_ld_s;
                    retire_s     = 1'b1;
                end
                default: begin
                    imem_req_s = 1'b0;
                end
            endcase
        end
    end

    // Main FSM: state, instruction register, trap flag and retirement counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= FETCH;
            ir_r      <= 32'h0000_0000;
            retired_r <= 32'd0;
            trap_r    <= 1'b0;
        end else begin
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end
            case (state_r)
                FETCH: begin
                    if (imem_ready) begin
                        ir_r    <= instr_rdata;
                        state_r <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_legal_s) begin
                        state_r <= EXEC;
                    end else begin
                        state_r <= TRAP;
                        trap_r  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_ld_s || is_sd_s) begin
                        state_r <= MEM;
                    end else if (is_rtype_s) begin
                        state_r <= WB;
                    end else if (is_beq_s) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= TRAP;
                        trap_r  <= 1'b1;
                    end
                end
                MEM: begin
                    if (is_ld_s) begin
                        if (dmem_ready) begin
                            state_r <= WB;
                        end
                    end else if (is_sd_s) begin
                        if (dmem_ready) begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= TRAP;
                        trap_r  <= 1'b1;
                    end
                end
                WB: begin
                    state_r <= FETCH;
                end
                TRAP: begin
                    state_r <= TRAP;
                    trap_r  <= 1'b1;
                end
                default: begin
                    // Unused encodings are treated as a fault and locked out
                    state_r <= TRAP;
                    trap_r  <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_s;
    assign dmem_read   = dmem_read_s;
    assign dmem_write  = dmem_write_s;
    assign pc_write    = pc_write_s;
    assign pc_src      = pc_src_s;
    assign alu_src     = alu_src_s;
    assign alu_op      = alu_op_s;
    assign reg_write   = reg_write_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign instruction = ir_r;
    assign trap        = trap_r;
    assign retired     = retired_r;
    assign state       = state_r;

endmodule
